// File: rtl/bridge_pkg.sv
// -----------------------------------------------------------------------------
// bridge_pkg
// Shared constants and helpers for the miniRV data bus bridge.
//   - PERIPH_BASE_HI : upper 20 address bits that select the MMIO window
//   - ADDR_*         : full byte addresses of the peripheral registers
//   - HEX_SEG        : hex nibble to active-low {dp,g,f,e,d,c,b,a} pattern
//   - reg_sel_e      : which peripheral register an address selects
//   - decode_reg     : full-address match to reg_sel_e
//   - hex_to_seg     : HEX_SEG lookup
// -----------------------------------------------------------------------------
package bridge_pkg;

    localparam logic [19:0] PERIPH_BASE_HI = 20'hFFFFF;

    localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_TDIV  = 32'hFFFF_F024;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;

    // Element [n] is the segment pattern for nibble n; dp is always off (1).
    localparam logic [15:0][7:0] HEX_SEG = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DIG,
        SEL_TIMER,
        SEL_TDIV,
        SEL_LED,
        SEL_SW
    } reg_sel_e;

    // Registers match on the whole address, so aliases inside the window
    // (e.g. 0xFFFF_F004) fall through to SEL_NONE and read as zero.
    function automatic reg_sel_e decode_reg(input logic [31:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            ADDR_DIG:   sel = SEL_DIG;
            ADDR_TIMER: sel = SEL_TIMER;
            ADDR_TDIV:  sel = SEL_TDIV;
            ADDR_LED:   sel = SEL_LED;
            ADDR_SW:    sel = SEL_SW;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
// Multiplexed driver for an 8-digit seven-segment display. Each digit is lit
// for SCAN_DIV cycles, then the scan moves to the next digit, wrapping 7 -> 0.
// Ports:
//   cpu_clk   in   clock, all state on rising edge
//   cpu_rst_n in   asynchronous active-low reset
//   value     in   32-bit display value, nibble k shown on digit k
//   seg_en    out  one-hot active-low digit enables
//   seg_code  out  active-low segments {dp,g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_scan
    import bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] value,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_code
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       idx;
    logic [3:0]       nibble;

    // Dwell counter and digit index. The index only advances when the dwell
    // counter wraps, so each digit is held for exactly SCAN_DIV cycles.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
        end else if (scan_cnt == CNT_MAX) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Outputs depend only on idx and the registered display value, so they
    // never glitch with the CPU address. {idx,2'b00} keeps the bit offset
    // wide enough to reach bit 28.
    always_comb begin
        nibble   = value[{idx, 2'b00} +: 4];
        seg_en   = ~(8'b0000_0001 << idx);
        seg_code = hex_to_seg(nibble);
    end

endmodule

// File: rtl/data_bus_bridge.sv
// -----------------------------------------------------------------------------
// data_bus_bridge
// Sits between the miniRV data port and DRAM. Accesses to 0xFFFF_Fxxx go to
// the MMIO registers (display, timer, prescaler, LEDs, switches); everything
// else passes straight through to DRAM. Reads are combinational; writes and
// all peripheral state are registered on cpu_clk.
// Ports:
//   cpu_clk, cpu_rst_n        clock and asynchronous active-low reset
//   cpu_addr/wen/wdata/rdata  CPU data port
//   dram_addr/wen/wdata/rdata DRAM port (addr and wdata pass through)
//   sw                        asynchronous board switches
//   led                       board LEDs
//   seg_en, seg_code          seven-segment digit enables and segments
// -----------------------------------------------------------------------------
module data_bus_bridge
    import bridge_pkg::*;
#(
    parameter int          SCAN_DIV      = 20000,
    parameter int unsigned TIMER_DIV_RST = 99
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_code
);

    logic        is_periph;
    reg_sel_e    reg_sel;
    logic [31:0] periph_rdata;

    logic        wr_dig;
    logic        wr_timer;
    logic        wr_tdiv;
    logic        wr_led;

    logic [31:0] dig_q;
    logic [31:0] timer_q;
    logic [31:0] tdiv_q;
    logic [31:0] presc_q;
    logic [23:0] led_q;
    logic [23:0] sw_meta;
    logic [23:0] sw_sync;
    logic        timer_tick;

    // Address decode and write strobes. A peripheral write never reaches
    // DRAM, even when it targets an unmapped hole in the MMIO window.
    always_comb begin
        is_periph = (cpu_addr[31:12] == PERIPH_BASE_HI);
        reg_sel   = is_periph ? decode_reg(cpu_addr) : SEL_NONE;
        wr_dig    = cpu_wen && (reg_sel == SEL_DIG);
        wr_timer  = cpu_wen && (reg_sel == SEL_TIMER);
        wr_tdiv   = cpu_wen && (reg_sel == SEL_TDIV);
        wr_led    = cpu_wen && (reg_sel == SEL_LED);
    end

    assign dram_addr  = cpu_addr;
    assign dram_wdata = cpu_wdata;
    assign dram_wen   = cpu_wen & ~is_periph;

    // Read mux. Unmapped peripheral addresses return zero.
    always_comb begin
        periph_rdata = 32'h0;
        case (reg_sel)
            SEL_DIG:   periph_rdata = dig_q;
            SEL_TIMER: periph_rdata = timer_q;
            SEL_TDIV:  periph_rdata = tdiv_q;
            SEL_LED:   periph_rdata = {8'h00, led_q};
            SEL_SW:    periph_rdata = {8'h00, sw_sync};
            default:   periph_rdata = 32'h0;
        endcase
        cpu_rdata = is_periph ? periph_rdata : dram_rdata;
    end

    // Plain CPU-writable registers: display value and LEDs.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            dig_q <= 32'h0;
            led_q <= 24'h0;
        end else begin
            if (wr_dig) begin
                dig_q <= cpu_wdata;
            end
            if (wr_led) begin
                led_q <= cpu_wdata[23:0];
            end
        end
    end

    assign timer_tick = (presc_q == tdiv_q);

    // Prescaled timer. presc runs 0..TDIV, so the timer period is TDIV+1
    // cycles and TDIV = 0 ticks every cycle. A CPU write to TIMER wins over
    // a coincident tick so software sees exactly what it wrote; a TDIV write
    // restarts the prescaler so the new period starts cleanly.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            timer_q <= 32'h0;
            tdiv_q  <= 32'(TIMER_DIV_RST);
            presc_q <= 32'h0;
        end else begin
            if (wr_tdiv) begin
                tdiv_q  <= cpu_wdata;
                presc_q <= 32'h0;
            end else if (timer_tick) begin
                presc_q <= 32'h0;
            end else begin
                presc_q <= presc_q + 32'd1;
            end

            if (wr_timer) begin
                timer_q <= cpu_wdata;
            end else if (timer_tick) begin
                timer_q <= timer_q + 32'd1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous switches; only the second
    // flop is ever read.
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            sw_meta <= 24'h0;
            sw_sync <= 24'h0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
        end
    end

    assign led = led_q;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg7_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .value     (dig_q),
        .seg_en    (seg_en),
        .seg_code  (seg_code)
    );

endmodule
